// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry first-word-fall-through queue between the fetch
// stage and decode. Holds {instruction, nextPc} pairs, supports simultaneous
// push/pop when full, and discards everything on a taken-branch flush.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [31:0]      nextPc,
  input  logic             hit,
  input  logic             flush,
  input  logic             decodeReady,
  output logic [31:0]      outInstruction,
  output logic [31:0]      outPc,
  output logic             outValid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic push;
  logic pop;
  logic empty;

  // Status decodes come only from registered occupancy, never from hit/decodeReady
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign outValid = ~empty;
  assign count    = count_q;

  // Handshake: a pop frees a slot so a full queue may still accept a push
  assign pop  = outValid & decodeReady & ~flush;
  assign push = hit & ~flush & (~full | pop);

  // Head entry falls through; outputs forced to zero when nothing is valid
  assign outInstruction = outValid ? instr_mem_q[head_q] : 32'h0000_0000;
  assign outPc          = outValid ? pc_mem_q[head_q]    : 32'h0000_0000;

  // Next-state for pointers and occupancy; flush overrides all traffic
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i]    <= 32'h0000_0000;
      end
    end else if (push) begin
      instr_mem_q[tail_q] <= instruction;
      pc_mem_q[tail_q]    <= nextPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] nextPc;
  logic        hit;
  logic        flush;
  logic        decodeReady;
  logic [31:0] outInstruction;
  logic [31:0] outPc;
  logic        outValid;
  logic        full;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clock          (clk),
    .reset          (reset),
    .instruction    (instruction),
    .nextPc         (nextPc),
    .hit            (hit),
    .flush          (flush),
    .decodeReady    (decodeReady),
    .outInstruction (outInstruction),
    .outPc          (outPc),
    .outValid       (outValid),
    .full           (full),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    hit         = 1'b1;
    instruction = instr_of(pc);
    nextPc      = pc;
    tick();
    hit         = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [31:0] pc);
    hit         = 1'b0;
    decodeReady = 1'b1;
    check({tag, "_valid"}, 32'(outValid), 32'd1);
    check({tag, "_pc"}, outPc, pc);
    check({tag, "_instr"}, outInstruction, instr_of(pc));
    tick();
    decodeReady = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_valid"}, 32'(outValid), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_instr"}, outInstruction, 32'd0);
    check({tag, "_pc"}, outPc, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 32'd0;
    nextPc      = 32'd0;
    hit         = 1'b0;
    flush       = 1'b0;
    decodeReady = 1'b0;

    // Reset state
    tick();
    check_empty("rst_hold");
    reset = 1'b0;
    tick();
    check_empty("rst_after");

    // Single push visible exactly one cycle later, no bypass
    hit         = 1'b1;
    instruction = 32'h8C01_0004;
    nextPc      = 32'h4;
    #1;
    check("no_bypass", 32'(outValid), 32'd0);
    tick();
    hit = 1'b0;
    check("single_valid", 32'(outValid), 32'd1);
    check("single_instr", outInstruction, 32'h8C01_0004);
    check("single_pc", outPc, 32'h4);
    check("single_count", 32'(count), 32'd1);
    decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    check_empty("single_drained");

    // Pop disabled while empty
    decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);

    // Fill, overflow drop, in-order drain
    push(32'd4);
    push(32'd8);
    push(32'd12);
    push(32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    push(32'd20);
    check("drop_count", 32'(count), 32'd4);
    check("drop_head", outPc, 32'd4);
    drain_expect("d1", 32'd4);
    check("d1_full_clear", 32'(full), 32'd0);
    drain_expect("d2", 32'd8);
    drain_expect("d3", 32'd12);
    drain_expect("d4", 32'd16);
    check_empty("drop_drained");

    // Full with simultaneous push and pop
    push(32'd4);
    push(32'd8);
    push(32'd12);
    push(32'd16);
    hit         = 1'b1;
    instruction = instr_of(32'd20);
    nextPc      = 32'd20;
    decodeReady = 1'b1;
    tick();
    hit         = 1'b0;
    decodeReady = 1'b0;
    check("pp_count", 32'(count), 32'd4);
    check("pp_full", 32'(full), 32'd1);
    drain_expect("pp1", 32'd8);
    drain_expect("pp2", 32'd12);
    drain_expect("pp3", 32'd16);
    drain_expect("pp4", 32'd20);
    check_empty("pp_drained");

    // Flush overrides hit and decodeReady
    push(32'h100);
    push(32'h104);
    push(32'h108);
    check("pre_flush_count", 32'(count), 32'd3);
    flush       = 1'b1;
    hit         = 1'b1;
    decodeReady = 1'b1;
    instruction = instr_of(32'h10C);
    nextPc      = 32'h10C;
    tick();
    flush       = 1'b0;
    hit         = 1'b0;
    decodeReady = 1'b0;
    check_empty("flush");
    push(32'h40);
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_pc", outPc, 32'h40);
    drain_expect("post_flush", 32'h40);

    // Alternating push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      pc = 32'h200 + 32'(i / 2) * 32'd4;
      if (i % 2 == 0) begin
        push(pc);
      end else begin
        drain_expect("alt", pc);
      end
      check("alt_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    check_empty("alt_end");

    // Asynchronous reset between edges
    push(32'h300);
    push(32'h304);
    check("pre_async_count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_empty("async_rst");
    #3;
    reset = 1'b0;
    tick();
    check_empty("async_rel");
    push(32'h500);
    check("after_rst_count", 32'(count), 32'd1);
    check("after_rst_pc", outPc, 32'h500);
    check("after_rst_instr", outInstruction, instr_of(32'h500));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
